// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target responder: FSM state encoding and
// the bus levels that mean ACK / NACK in the acknowledge slot.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    ADDR       = 4'd1,
    ADDR_ACK   = 4'd2,
    WR_BYTE    = 4'd3,
    WR_ACK     = 4'd4,
    RD_STRETCH = 4'd5,
    RD_BYTE    = 4'd6,
    RD_ACKCHK  = 4'd7,
    IGNORE     = 4'd8
  } i2c_state_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push and a pop in the same cycle
// both succeed even when full or empty (empty case forwards push_data).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_r;
  logic [AW:0]      rptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty     = (wptr_r == rptr_r);
  assign full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign push_ok_s = push & (~full | pop);
  assign pop_ok_s  = pop & (~empty | push);

  // Read port: head entry, or the incoming word when passing through an empty FIFO.
  always_comb begin
    pop_data = '0;
    if (!empty) begin
      pop_data = mem_r[rptr_r[AW-1:0]];
    end else if (push) begin
      pop_data = push_data;
    end else begin
      pop_data = '0;
    end
  end

  // Storage array; no reset needed since empty/full gate every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wptr_r[AW-1:0]] <= push_data;
    end
  end

  // Pointer update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wptr_r <= wptr_r + 1'b1;
      end
      if (pop_ok_s) begin
        rptr_r <= rptr_r + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target that serves one of several buses: writes land in a FIFO for the
// host, reads are fed from a host-filled FIFO, with clock stretching when dry.
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter int                        NUM_I2C_BUSSES = 1,
  parameter int                        I2C_ADDR_WIDTH = 7,
  parameter logic [I2C_ADDR_WIDTH-1:0] ADDRESS        = 7'h22,
  parameter int                        DEPTH          = 16
) (
  input  logic                                                       clk,
  input  logic                                                       rst,
  input  logic [((NUM_I2C_BUSSES > 1) ? $clog2(NUM_I2C_BUSSES) : 1)-1:0] bus_sel,
  input  logic [NUM_I2C_BUSSES-1:0]                                  scl_i,
  input  logic [NUM_I2C_BUSSES-1:0]                                  sda_i,
  output logic [NUM_I2C_BUSSES-1:0]                                  scl_oe,
  output logic [NUM_I2C_BUSSES-1:0]                                  sda_oe,
  output logic [7:0]                                                 wr_data,
  output logic                                                       wr_valid,
  input  logic                                                       wr_ready,
  input  logic [7:0]                                                 rd_data,
  input  logic                                                       rd_valid,
  output logic                                                       rd_ready,
  output logic                                                       evt_start,
  output logic                                                       evt_stop,
  output logic                                                       evt_nack,
  output logic                                                       ovf
);

  localparam int         SEL_W     = (NUM_I2C_BUSSES > 1) ? $clog2(NUM_I2C_BUSSES) : 1;
  localparam int         ADDR_BITS = I2C_ADDR_WIDTH + 1;
  localparam logic [3:0] ADDR_CNT  = 4'(ADDR_BITS);

  i2c_state_e                state_r, state_nx;
  logic [SEL_W-1:0]          sel_r, sel_nx;
  logic [3:0]                cnt_r, cnt_nx;
  logic [7:0]                sh_r, sh_nx;
  logic                      rw_r, rw_nx;
  logic                      flag_r, flag_nx;
  logic                      drv_scl_r, drv_scl_nx;
  logic                      drv_sda_r, drv_sda_nx;
  logic                      ovf_r, ovf_nx;
  logic                      evt_start_r, evt_start_nx;
  logic                      evt_stop_r, evt_stop_nx;
  logic                      evt_nack_r, evt_nack_nx;
  logic [NUM_I2C_BUSSES-1:0] scl_oe_r, sda_oe_r;
  logic [NUM_I2C_BUSSES-1:0] sel_onehot_s;

  logic scl_raw_s, sda_raw_s;
  logic scl_meta_r, scl_sync_r, scl_prev_r;
  logic sda_meta_r, sda_sync_r, sda_prev_r;
  logic scl_rise_s, scl_fall_s, start_s, stop_s, addr_hit_s, rd_next_s;
  logic w_push_s, w_full_s, w_empty_s;
  logic r_pop_s, r_full_s, r_empty_s;
  logic [7:0] r_pop_data_s;

  // Decode the latched bus selection; an out-of-range selection serves nothing.
  always_comb begin
    sel_onehot_s = '0;
    for (int b = 0; b < NUM_I2C_BUSSES; b++) begin
      sel_onehot_s[b] = (sel_r == SEL_W'(b));
    end
  end

  assign scl_raw_s = |(scl_i & sel_onehot_s) | ~|sel_onehot_s;
  assign sda_raw_s = |(sda_i & sel_onehot_s) | ~|sel_onehot_s;

  // Two-flop synchroniser per line plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_meta_r <= 1'b1;
      scl_sync_r <= 1'b1;
      scl_prev_r <= 1'b1;
      sda_meta_r <= 1'b1;
      sda_sync_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_meta_r <= scl_raw_s;
      scl_sync_r <= scl_meta_r;
      scl_prev_r <= scl_sync_r;
      sda_meta_r <= sda_raw_s;
      sda_sync_r <= sda_meta_r;
      sda_prev_r <= sda_sync_r;
    end
  end

  assign scl_rise_s = scl_sync_r & ~scl_prev_r;
  assign scl_fall_s = ~scl_sync_r & scl_prev_r;
  assign start_s    = scl_sync_r & scl_prev_r & sda_prev_r & ~sda_sync_r;
  assign stop_s     = scl_sync_r & scl_prev_r & ~sda_prev_r & sda_sync_r;
  assign addr_hit_s = (sh_r[ADDR_BITS-1:1] == ADDRESS);

  // Next-state logic: bus conditions override, then per-state bit handling.
  always_comb begin
    state_nx     = state_r;
    sel_nx       = sel_r;
    cnt_nx       = cnt_r;
    sh_nx        = sh_r;
    rw_nx        = rw_r;
    flag_nx      = flag_r;
    drv_scl_nx   = drv_scl_r;
    drv_sda_nx   = drv_sda_r;
    ovf_nx       = ovf_r;
    evt_start_nx = 1'b0;
    evt_stop_nx  = 1'b0;
    evt_nack_nx  = 1'b0;
    w_push_s     = 1'b0;
    r_pop_s      = 1'b0;
    rd_next_s    = 1'b0;

    if (stop_s) begin
      state_nx    = IDLE;
      drv_scl_nx  = 1'b0;
      drv_sda_nx  = 1'b0;
      cnt_nx      = 4'd0;
      flag_nx     = 1'b0;
      evt_stop_nx = 1'b1;
    end else if (start_s) begin
      state_nx     = ADDR;
      drv_scl_nx   = 1'b0;
      drv_sda_nx   = 1'b0;
      cnt_nx       = 4'd0;
      flag_nx      = 1'b0;
      evt_start_nx = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          sel_nx     = bus_sel;
          drv_scl_nx = 1'b0;
          drv_sda_nx = 1'b0;
        end
        ADDR: begin
          if (scl_rise_s && (cnt_r < ADDR_CNT)) begin
            sh_nx  = {sh_r[6:0], sda_sync_r};
            cnt_nx = cnt_r + 4'd1;
          end else if (scl_fall_s && (cnt_r == ADDR_CNT)) begin
            if (addr_hit_s) begin
              drv_sda_nx = ~ACK;
              rw_nx      = sh_r[0];
              state_nx   = ADDR_ACK;
            end else begin
              state_nx = IGNORE;
            end
          end else begin
            state_nx = state_r;
          end
        end
        ADDR_ACK: begin
          if (scl_fall_s) begin
            drv_sda_nx = 1'b0;
            cnt_nx     = 4'd0;
            rd_next_s  = rw_r;
            state_nx   = rw_r ? state_r : WR_BYTE;
          end else begin
            state_nx = state_r;
          end
        end
        WR_BYTE: begin
          if (scl_rise_s && (cnt_r < 4'd8)) begin
            sh_nx  = {sh_r[6:0], sda_sync_r};
            cnt_nx = cnt_r + 4'd1;
          end else if (scl_fall_s && (cnt_r == 4'd8)) begin
            // A full FIFO drops the byte and answers NACK.
            if (!w_full_s) begin
              w_push_s   = 1'b1;
              drv_sda_nx = ~ACK;
            end else begin
              drv_sda_nx = ~NACK;
              ovf_nx     = 1'b1;
            end
            state_nx = WR_ACK;
          end else begin
            state_nx = state_r;
          end
        end
        WR_ACK: begin
          if (scl_fall_s) begin
            drv_sda_nx = 1'b0;
            cnt_nx     = 4'd0;
            state_nx   = WR_BYTE;
          end else begin
            state_nx = state_r;
          end
        end
        RD_STRETCH: begin
          // flag_r marks that the MSB is already on sda; release scl one cycle later.
          if (!flag_r) begin
            if (!r_empty_s) begin
              r_pop_s    = 1'b1;
              sh_nx      = r_pop_data_s;
              drv_sda_nx = ~r_pop_data_s[7];
              flag_nx    = 1'b1;
            end else begin
              drv_scl_nx = 1'b1;
            end
          end else begin
            drv_scl_nx = 1'b0;
            flag_nx    = 1'b0;
            cnt_nx     = 4'd0;
            state_nx   = RD_BYTE;
          end
        end
        RD_BYTE: begin
          if (scl_fall_s) begin
            if (cnt_r == 4'd7) begin
              drv_sda_nx = 1'b0;
              flag_nx    = 1'b0;
              state_nx   = RD_ACKCHK;
            end else begin
              cnt_nx     = cnt_r + 4'd1;
              sh_nx      = {sh_r[6:0], 1'b0};
              drv_sda_nx = ~sh_r[6];
            end
          end else begin
            state_nx = state_r;
          end
        end
        RD_ACKCHK: begin
          if (scl_rise_s) begin
            if (sda_sync_r == ACK) begin
              flag_nx = 1'b1;
            end else begin
              evt_nack_nx = 1'b1;
              state_nx    = IGNORE;
            end
          end else if (scl_fall_s && flag_r) begin
            flag_nx   = 1'b0;
            cnt_nx    = 4'd0;
            rd_next_s = 1'b1;
          end else begin
            state_nx = state_r;
          end
        end
        IGNORE: begin
          drv_scl_nx = 1'b0;
          drv_sda_nx = 1'b0;
        end
        default: begin
          state_nx   = IDLE;
          drv_scl_nx = 1'b0;
          drv_sda_nx = 1'b0;
        end
      endcase

      // Fetch the next read byte at the falling edge, stretching if none is queued.
      if (rd_next_s) begin
        if (!r_empty_s) begin
          r_pop_s    = 1'b1;
          sh_nx      = r_pop_data_s;
          drv_sda_nx = ~r_pop_data_s[7];
          state_nx   = RD_BYTE;
        end else begin
          drv_scl_nx = 1'b1;
          flag_nx    = 1'b0;
          state_nx   = RD_STRETCH;
        end
      end else begin
        r_pop_s = r_pop_s;
      end
    end
  end

  // State and output registers; oe lines are only ever driven on the latched bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      sel_r       <= '0;
      cnt_r       <= 4'd0;
      sh_r        <= 8'd0;
      rw_r        <= 1'b0;
      flag_r      <= 1'b0;
      drv_scl_r   <= 1'b0;
      drv_sda_r   <= 1'b0;
      ovf_r       <= 1'b0;
      evt_start_r <= 1'b0;
      evt_stop_r  <= 1'b0;
      evt_nack_r  <= 1'b0;
      scl_oe_r    <= '0;
      sda_oe_r    <= '0;
    end else begin
      state_r     <= state_nx;
      sel_r       <= sel_nx;
      cnt_r       <= cnt_nx;
      sh_r        <= sh_nx;
      rw_r        <= rw_nx;
      flag_r      <= flag_nx;
      drv_scl_r   <= drv_scl_nx;
      drv_sda_r   <= drv_sda_nx;
      ovf_r       <= ovf_nx;
      evt_start_r <= evt_start_nx;
      evt_stop_r  <= evt_stop_nx;
      evt_nack_r  <= evt_nack_nx;
      scl_oe_r    <= drv_scl_nx ? sel_onehot_s : '0;
      sda_oe_r    <= drv_sda_nx ? sel_onehot_s : '0;
    end
  end

  assign scl_oe    = scl_oe_r;
  assign sda_oe    = sda_oe_r;
  assign ovf       = ovf_r;
  assign evt_start = evt_start_r;
  assign evt_stop  = evt_stop_r;
  assign evt_nack  = evt_nack_r;
  assign wr_valid  = ~w_empty_s;
  assign rd_ready  = ~r_full_s;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push_s),
    .push_data (sh_r),
    .pop       (wr_ready & ~w_empty_s),
    .pop_data  (wr_data),
    .full      (w_full_s),
    .empty     (w_empty_s)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_valid & ~r_full_s),
    .push_data (rd_data),
    .pop       (r_pop_s),
    .pop_data  (r_pop_data_s),
    .full      (r_full_s),
    .empty     (r_empty_s)
  );

endmodule

// File: doc/i2c_slave_responder.md
I2C_SLAVE_RESPONDER -- requirements
Module: i2c_slave_responder

Interface
REQ-001 SHALL have parameter NUM_I2C_BUSSES, default 1: number of I2C buses monitored.
REQ-002 SHALL have parameter I2C_ADDR_WIDTH, default 7: target address width.
REQ-003 SHALL have parameter ADDRESS, default 7'h22: own target address.
REQ-004 SHALL have parameter DEPTH, default 16: entries per FIFO; power of two, at least 2.
REQ-005 SHALL have port clk, input, 1: system clock.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port bus_sel, input, max(1,clog2(NUM_I2C_BUSSES)): selects the bus to serve.
REQ-008 SHALL have ports scl_i and sda_i, input, NUM_I2C_BUSSES: raw bus line levels.
REQ-009 SHALL have ports scl_oe and sda_oe, output, NUM_I2C_BUSSES: 1 pulls that line low (open-drain).
REQ-010 SHALL have port wr_data, output, 8: oldest received write byte.
REQ-011 SHALL have ports wr_valid (output, 1) and wr_ready (input, 1): write-FIFO pop handshake.
REQ-012 SHALL have port rd_data, input, 8: byte to return on reads.
REQ-013 SHALL have ports rd_valid (input, 1) and rd_ready (output, 1): read-FIFO push handshake.
REQ-014 SHALL have ports evt_start, evt_stop and evt_nack, output, 1 each: one-cycle event pulses.
REQ-015 SHALL have port ovf, output, 1: sticky write-FIFO overflow flag; cleared only by reset.

Function
REQ-016 SHALL pass the selected bus's scl and sda through 2-flop synchronisers; all edge detection uses the synchronised values.
REQ-017 SHALL latch bus_sel only in IDLE; changes during a transfer take effect on return to IDLE.
REQ-018 SHALL treat sda falling while scl is high as START (also repeated START); SHALL pulse evt_start and enter ADDR from any state.
REQ-019 SHALL treat sda rising while scl is high as STOP; SHALL pulse evt_stop and enter IDLE from any state, releasing both oe lines within 1 clk.
REQ-020 SHALL define FSM states IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_STRETCH, RD_BYTE, RD_ACKCHK and IGNORE.
REQ-021 ADDR SHALL shift address bits then the R/W bit, MSB first, sampling on each scl rising edge.
REQ-022 On address match, SHALL drive sda_oe from the scl falling edge after bit 8 through the next scl falling edge (ACK).
REQ-023 On address mismatch, SHALL leave sda released and go to IGNORE until the next START or STOP.
REQ-024 In WR_BYTE, SHALL shift 8 data bits; if the write FIFO has space, SHALL push the byte and ACK per REQ-022.
REQ-025 If the write FIFO is full after the 8th bit, SHALL NACK (sda released), drop the byte and set ovf.
REQ-026 After R=1 ACK, or after a master ACK in RD_ACKCHK, SHALL pop the read FIFO at the scl falling edge; if it is empty, SHALL enter RD_STRETCH with scl_oe asserted.
REQ-027 RD_STRETCH SHALL release scl 1 clk after data is available, presenting the MSB on sda at least 1 clk before release.
REQ-028 RD_BYTE SHALL update sda on scl falling edges and drive it by setting sda_oe = ~bit.
REQ-029 RD_BYTE SHALL release sda after the 8th falling edge.
REQ-030 RD_ACKCHK SHALL sample sda on scl rising: low continues to the next byte; high pulses evt_nack and goes to IGNORE.
REQ-031 SHALL drive the oe outputs only on the latched bus; oe bits of all other buses SHALL be 0.
REQ-032 FIFO pointers SHALL carry one extra wrap bit; FIFO full/empty SHALL follow from pointer comparison.
REQ-033 A simultaneous push and pop on a full or empty FIFO SHALL both succeed, leaving the count unchanged.
REQ-034 rd_ready SHALL equal not-full of the read FIFO; wr_valid SHALL equal not-empty of the write FIFO.

Reset
REQ-035 While rst=0, SHALL hold the FSM in IDLE, hold all oe outputs, event pulses, ovf, wr_valid and wr_data at 0, set rd_ready=1 and empty both FIFOs.
REQ-036 Reset asserted mid-transfer SHALL release both bus lines asynchronously, with no wait for clk.

Structure
REQ-037 SHALL define the FSM state enum and the ACK/NACK constants in shared package i2c_pkg.
REQ-038 SHALL instantiate sub-module sync_fifo (params WIDTH, DEPTH) twice, one per direction.

Verification
REQ-039 Write to 0x22 of bytes 0x00..0x1F, DEPTH=16, no pops: 16 ACKs, 17th byte NACKed, ovf=1, FIFO pops 0x00..0x0F.
REQ-040 Read from 0x22 with an empty read FIFO, then push 0xA5 after 200 clk: scl held low about 200 clk; master receives 0xA5.
REQ-041 Address 0x23 write: no ACK, no FIFO push; the next START to 0x22 is ACKed.
REQ-042 Read 3 bytes 0x11,0x22,0x33 with the master NACKing the third: data matches; evt_nack pulses once; sda is released.
REQ-043 NUM_I2C_BUSSES=4, bus_sel=2: only scl_oe[2]/sda_oe[2] ever toggle; traffic on bus 0 is ignored.
REQ-044 Drive rst low mid-ACK: sda_oe drops to 0 without waiting for clk; after reset, FIFOs are empty and the FSM is in IDLE.
